// File: rtl/addition_layer_seq_if.sv
// addition_layer_seq_if: start/beat/result bundle for the ASCON round-constant addition unit.
// i_bypass exists only when ADDITION_SEQ_BYPASS_EN is defined.
interface addition_layer_seq_if #(
    parameter int NB_WORDS   = 5,
    parameter int WORD_WIDTH = 64,
    parameter int MAX_ROUNDS = 12,
    parameter int RND_W      = $clog2(MAX_ROUNDS + 1)
);
    logic                                i_start;
    logic [RND_W-1:0]                    i_rounds;
    logic                                i_valid;
    logic [NB_WORDS-1:0][WORD_WIDTH-1:0] i_state;
`ifdef ADDITION_SEQ_BYPASS_EN
    logic                                i_bypass;
`endif
    logic [NB_WORDS-1:0][WORD_WIDTH-1:0] o_state;
    logic                                o_valid;
    logic [RND_W-1:0]                    o_round;
    logic                                o_last;
    logic                                o_done;
    logic                                o_busy;
    logic                                o_error;

    modport master (
`ifdef ADDITION_SEQ_BYPASS_EN
        output i_bypass,
`endif
        output i_start, i_rounds, i_valid, i_state,
        input  o_state, o_valid, o_round, o_last, o_done, o_busy, o_error
    );

    modport slave (
`ifdef ADDITION_SEQ_BYPASS_EN
        input  i_bypass,
`endif
        input  i_start, i_rounds, i_valid, i_state,
        output o_state, o_valid, o_round, o_last, o_done, o_busy, o_error
    );
endinterface

// File: rtl/addition_layer_seq.sv
// addition_layer_seq: round counter + registered round-constant addition for the iterative ASCON permutation.
// ADDITION_SEQ_BYPASS_EN adds i_bypass, which registers beats without the constant.
module addition_layer_seq #(
    parameter int NB_WORDS    = 5,
    parameter int WORD_WIDTH  = 64,
    parameter int TARGET_WORD = 2,
    parameter int MAX_ROUNDS  = 12,
    parameter int RND_W       = $clog2(MAX_ROUNDS + 1)
) (
    input logic                 clock,
    input logic                 reset_n,
    addition_layer_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [RND_W-1:0] MAX_R  = RND_W'(MAX_ROUNDS);
    localparam logic [RND_W-1:0] LAST_R = RND_W'(MAX_ROUNDS - 1);

    fsm_t                                fsm, fsm_nx;
    logic [RND_W-1:0]                    round_idx, round_idx_nx, o_round_nx;
    logic [NB_WORDS-1:0][WORD_WIDTH-1:0] o_state_nx, added;
    logic                                o_valid_nx, o_last_nx, o_done_nx, o_error_nx;
    logic                                start_ok;
    logic [7:0]                          rc, rc_key;

    assign rc       = {4'(4'd15 - 4'(round_idx)), 4'(round_idx)};
    assign start_ok = bus.i_rounds != '0 && bus.i_rounds <= MAX_R;
    assign bus.o_busy = fsm != IDLE;

`ifdef ADDITION_SEQ_BYPASS_EN
    logic bypass;
    always_ff @(posedge clock) begin
        if (!reset_n)
            bypass <= 1'b0;
        else if (fsm == IDLE && bus.i_start)
            bypass <= bus.i_bypass;
    end
    assign rc_key = bypass ? 8'h00 : rc;
`else
    assign rc_key = rc;
`endif

    always_comb begin
        added = bus.i_state;
        added[TARGET_WORD] = bus.i_state[TARGET_WORD] ^ WORD_WIDTH'(rc_key);
    end

    // Flags default low every cycle so valid/last/done/error are single-cycle pulses.
    always_comb begin
        fsm_nx       = fsm;
        round_idx_nx = round_idx;
        o_state_nx   = bus.o_state;
        o_round_nx   = bus.o_round;
        o_valid_nx   = 1'b0;
        o_last_nx    = 1'b0;
        o_done_nx    = 1'b0;
        o_error_nx   = 1'b0;
        if (fsm == IDLE && bus.i_start) begin
            if (start_ok) begin
                fsm_nx       = RUN;
                round_idx_nx = MAX_R - bus.i_rounds;
            end else
                o_error_nx = 1'b1;
        end else if (fsm == RUN && bus.i_valid) begin
            o_state_nx = added;
            o_round_nx = round_idx;
            o_valid_nx = 1'b1;
            if (round_idx == LAST_R) begin
                o_last_nx = 1'b1;
                fsm_nx    = DONE;
            end else
                round_idx_nx = round_idx + RND_W'(1);
        end else if (fsm == DONE) begin
            o_done_nx = 1'b1;
            fsm_nx    = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fsm         <= IDLE;
            round_idx   <= '0;
            bus.o_state <= '0;
            bus.o_round <= '0;
            bus.o_valid <= 1'b0;
            bus.o_last  <= 1'b0;
            bus.o_done  <= 1'b0;
            bus.o_error <= 1'b0;
        end else begin
            fsm         <= fsm_nx;
            round_idx   <= round_idx_nx;
            bus.o_state <= o_state_nx;
            bus.o_round <= o_round_nx;
            bus.o_valid <= o_valid_nx;
            bus.o_last  <= o_last_nx;
            bus.o_done  <= o_done_nx;
            bus.o_error <= o_error_nx;
        end
    end
endmodule

// File: tb/tb_addition_layer_seq.sv
// tb_addition_layer_seq: directed runs with a scoreboard of expected beats for addition_layer_seq.
module tb_addition_layer_seq;
    typedef logic [4:0][63:0] st_t;
    typedef struct {
        st_t        st;
        logic [3:0] rnd;
        logic       last;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mr = 0;
    exp_t exp_q[$];
    st_t  last_exp;
    st_t  s;
    logic [7:0] tbl [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                             8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    addition_layer_seq_if #(.NB_WORDS(5), .WORD_WIDTH(64), .MAX_ROUNDS(12)) bus ();

    addition_layer_seq #(.NB_WORDS(5), .WORD_WIDTH(64), .TARGET_WORD(2), .MAX_ROUNDS(12)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rc(input int r);
        return 64'({4'(15 - r), 4'(r)});
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input int n);
        bus.i_start  = 1'b1;
        bus.i_rounds = 4'(n);
        cyc();
        bus.i_start = 1'b0;
        mr = 12 - n;
    endtask

    task automatic beat(input st_t x);
        exp_t e;
        e.st    = x;
        e.st[2] = x[2] ^ rc(mr);
        e.rnd   = 4'(mr);
        e.last  = (mr == 11);
        exp_q.push_back(e);
        last_exp = e.st;
        bus.i_valid = 1'b1;
        bus.i_state = x;
        cyc();
        bus.i_valid = 1'b0;
        mr++;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_state"}, 320'(bus.o_state), 320'(0));
        check({tag, "_round"}, 320'(bus.o_round), 320'(0));
        check({tag, "_flags"}, 320'({bus.o_valid, bus.o_last, bus.o_done, bus.o_busy, bus.o_error}), 320'(0));
    endtask

    always @(negedge clock) begin
        if (bus.o_valid) begin
            if (exp_q.size() == 0)
                check("sb_spurious_valid", 320'(bus.o_valid), 320'(0));
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_state", 320'(bus.o_state), 320'(e.st));
                check("sb_round", 320'(bus.o_round), 320'(e.rnd));
                check("sb_last", 320'(bus.o_last), 320'(e.last));
            end
        end
    end

    initial begin
        bus.i_start  = 1'b0;
        bus.i_rounds = '0;
        bus.i_valid  = 1'b0;
        bus.i_state  = '0;
`ifdef ADDITION_SEQ_BYPASS_EN
        bus.i_bypass = 1'b0;
`endif
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (5) cyc();
        check_idle_zero("reset_idle");

        // Full 12-round run on an all-zero state.
        start(12);
        check("run12_busy", 320'(bus.o_busy), 320'(1));
        for (int i = 0; i < 12; i++) begin
            beat('0);
            check($sformatf("run12_word2_%0d", i), 320'(bus.o_state[2]), 320'(tbl[i]));
        end
        check("run12_last", 320'(bus.o_last), 320'(1));
        cyc();
        check("run12_done", 320'({bus.o_done, bus.o_valid, bus.o_last, bus.o_busy}), 320'(4'b1000));
        check("run12_hold", 320'(bus.o_state[2]), 320'(64'h4B));
        cyc();
        check("run12_done_pulse", 320'(bus.o_done), 320'(0));

        // 6-round run: starts at absolute round 6.
        s = '0;
        for (int w = 0; w < 5; w++) s[w] = 64'h0123_4567_89AB_CDEF;
        s[2] = '1;
        start(6);
        beat(s);
        check("run6_round", 320'(bus.o_round), 320'(6));
        check("run6_word2", 320'(bus.o_state[2]), 320'(64'hFFFF_FFFF_FFFF_FF69));
        check("run6_word0", 320'(bus.o_state[0]), 320'(64'h0123_4567_89AB_CDEF));
        check("run6_word4", 320'(bus.o_state[4]), 320'(64'h0123_4567_89AB_CDEF));
        for (int i = 1; i < 6; i++) beat(s);
        check("run6_last_round", 320'({bus.o_last, bus.o_round}), 320'({1'b1, 4'd11}));
        cyc();
        check("run6_done", 320'(bus.o_done), 320'(1));

        // 8-round run with a 3-cycle stall after beat 2.
        start(8);
        beat('0);
        beat(64'h55);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_valid", 320'(bus.o_valid), 320'(0));
            check("stall_state", 320'(bus.o_state), 320'(last_exp));
            check("stall_round", 320'(bus.o_round), 320'(5));
        end
        beat('0);
        check("resume_round", 320'(bus.o_round), 320'(6));
        check("resume_word2", 320'(bus.o_state[2]), 320'(64'h96));
        for (int i = 0; i < 5; i++) beat('0);
        cyc();
        check("run8_done", 320'(bus.o_done), 320'(1));

        // Illegal round counts.
        bus.i_start  = 1'b1;
        bus.i_rounds = 4'd0;
        cyc();
        bus.i_start = 1'b0;
        check("err0_pulse", 320'({bus.o_error, bus.o_busy}), 320'(2'b10));
        cyc();
        check("err0_clear", 320'(bus.o_error), 320'(0));
        bus.i_start  = 1'b1;
        bus.i_rounds = 4'd13;
        cyc();
        bus.i_start = 1'b0;
        check("err13_pulse", 320'({bus.o_error, bus.o_busy}), 320'(2'b10));
        cyc();
        check("err13_clear", 320'({bus.o_error, bus.o_busy}), 320'(0));

        // Start with i_valid in IDLE, then i_start held high through the run.
        bus.i_start  = 1'b1;
        bus.i_rounds = 4'd3;
        bus.i_valid  = 1'b1;
        bus.i_state  = '1;
        cyc();
        mr = 9;
        bus.i_valid  = 1'b0;
        check("startvalid_no_beat", 320'({bus.o_valid, bus.o_busy}), 320'(2'b01));
        bus.i_rounds = 4'd1;
        for (int i = 0; i < 3; i++) beat('1);
        bus.i_start = 1'b0;
        check("restart_ignored_round", 320'({bus.o_last, bus.o_round}), 320'({1'b1, 4'd11}));
        cyc();
        check("restart_ignored_done", 320'({bus.o_done, bus.o_error}), 320'(2'b10));

        // Reset in the middle of a 12-round run.
        start(12);
        for (int i = 0; i < 4; i++) beat(64'hA5);
        reset_n = 1'b0;
        cyc();
        check_idle_zero("midreset");
        reset_n = 1'b1;
        cyc();
        check("midreset_no_done", 320'({bus.o_done, bus.o_busy}), 320'(0));
        start(12);
        beat('0);
        check("rerun_round0", 320'({bus.o_round, bus.o_state[2]}), 320'({4'd0, 64'hF0}));
        for (int i = 1; i < 12; i++) beat('0);
        cyc();
        check("rerun_done", 320'(bus.o_done), 320'(1));
        cyc();
        check("sb_empty", 320'(exp_q.size()), 320'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
